// File: rtl/simt_divergence_stack_if.sv
// Branch-unit op channel into the SIMT divergence stack, plus the op encoding it carries.
package simt_pkg;
    typedef enum logic [1:0] {
        BRA_NONE = 2'd0,
        BRA_PUSH = 2'd1,
        BRA_POP  = 2'd2
    } branch_op_t;
endpackage

interface simt_divergence_stack_if
    import simt_pkg::*;
#(
    parameter int NUM_THREADS = 32,
    parameter int XLEN        = 32
);
    logic                   op_valid_i;
    logic                   op_ready_o;
    branch_op_t             op_i;
    logic [XLEN-1:0]        push_rpc_i;
    logic [XLEN-1:0]        push_else_pc_i;
    logic [NUM_THREADS-1:0] push_taken_mask_i;
    logic [NUM_THREADS-1:0] push_else_mask_i;

    modport master (
        output op_valid_i, op_i, push_rpc_i, push_else_pc_i, push_taken_mask_i, push_else_mask_i,
        input  op_ready_o
    );

    modport slave (
        input  op_valid_i, op_i, push_rpc_i, push_else_pc_i, push_taken_mask_i, push_else_mask_i,
        output op_ready_o
    );
endinterface

// File: rtl/simt_divergence_stack.sv
// Per-warp reconvergence stack: divergent pushes stack {rpc, mask} and {else_pc, else_mask};
// pops restore the top mask and redirect fetch to its PC.
`ifndef SIMT_STACK_DEPTH
`define SIMT_STACK_DEPTH 16
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef KIANA_SP_ERR_SIMT_STACK_OVERFLOW
`define KIANA_SP_ERR_SIMT_STACK_OVERFLOW 5
`endif
`ifndef KIANA_SP_ERR_SIMT_STACK_UNDERFLOW
`define KIANA_SP_ERR_SIMT_STACK_UNDERFLOW 6
`endif

module simt_divergence_stack
    import simt_pkg::*;
#(
    parameter int NUM_THREADS = 32,
    parameter int DEPTH       = `SIMT_STACK_DEPTH,
    parameter int XLEN        = `XLEN,
    localparam int DW         = $clog2(DEPTH) + 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_valid_i,
    input  logic [NUM_THREADS-1:0]  init_mask_i,
    simt_divergence_stack_if.slave  br,
    output logic [NUM_THREADS-1:0]  active_mask_o,
    output logic                    redirect_valid_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    output logic [DW-1:0]           depth_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [31:0]             err_o
);
    logic [DEPTH-1:0][XLEN-1:0]        pc_st;
    logic [DEPTH-1:0][NUM_THREADS-1:0] mask_st;

    logic [NUM_THREADS-1:0] mask_q, mask_d;
    logic [XLEN-1:0]        rpc_q, rpc_d;
    logic                   redir_q, redir_d;
    logic [DW-1:0]          depth_q, depth_d;
    logic [31:0]            err_q, err_d;

    logic          op_ready, accept, divergent, full, empty;
    logic          push_ok, pop_ok, ovf, unf;
    logic [AW-1:0] wr0_idx, wr1_idx, top_idx;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q > DW'(DEPTH - 2));
    assign wr0_idx = depth_q[AW-1:0];
    assign wr1_idx = wr0_idx + 1'b1;
    assign top_idx = wr0_idx - 1'b1;

    // The redirect cycle is a forced bubble so fetch can settle on the new PC.
    assign op_ready  = !rst && !init_valid_i && !redir_q;
    assign accept    = br.op_valid_i && op_ready;
    assign divergent = (|br.push_taken_mask_i) && (|br.push_else_mask_i);
    assign push_ok   = accept && (br.op_i == BRA_PUSH) && divergent && !full;
    assign ovf       = accept && (br.op_i == BRA_PUSH) && divergent && full;
    assign pop_ok    = accept && (br.op_i == BRA_POP) && !empty;
    assign unf       = accept && (br.op_i == BRA_POP) && empty;

    always_comb begin
        mask_d  = mask_q;
        rpc_d   = rpc_q;
        redir_d = 1'b0;
        depth_d = depth_q;
        err_d   = err_q;
        if (init_valid_i) begin
            depth_d = '0;
            mask_d  = init_mask_i;
        end else if (push_ok) begin
            depth_d = depth_q + DW'(2);
            mask_d  = br.push_taken_mask_i;
        end else if (pop_ok) begin
            depth_d = depth_q - DW'(1);
            mask_d  = mask_st[top_idx];
            rpc_d   = pc_st[top_idx];
            redir_d = 1'b1;
        end
        if (ovf) err_d[`KIANA_SP_ERR_SIMT_STACK_OVERFLOW]  = 1'b1;
        if (unf) err_d[`KIANA_SP_ERR_SIMT_STACK_UNDERFLOW] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '1;
            rpc_q   <= '0;
            redir_q <= 1'b0;
            depth_q <= '0;
            err_q   <= '0;
        end else begin
            mask_q  <= mask_d;
            rpc_q   <= rpc_d;
            redir_q <= redir_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Entry storage needs no reset; only depth_q says which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_st[wr0_idx]   <= br.push_rpc_i;
            mask_st[wr0_idx] <= mask_q;
            pc_st[wr1_idx]   <= br.push_else_pc_i;
            mask_st[wr1_idx] <= br.push_else_mask_i;
        end
    end

    assign br.op_ready_o    = op_ready;
    assign active_mask_o    = mask_q;
    assign redirect_valid_o = redir_q;
    assign redirect_pc_o    = rpc_q;
    assign depth_o          = depth_q;
    assign empty_o          = empty;
    assign full_o           = full;
    assign err_o            = err_q;
endmodule
